// File: rtl/rtc_time_ascii_tx.sv
// rtc_time_ascii_tx: snapshots the RTC BCD time registers on start and
// streams them as an ASCII record "20YY-MM-DD hh:mm:ss W" (+ optional CR LF).
//
// Stream handshake: a byte transfers on any rising edge where tx_valid and
// tx_ready are both high; while tx_valid=1 and tx_ready=0, tx_data and tx_valid
// hold their values, and tx_valid only falls after a transfer (or on reset).
module rtc_time_ascii_tx #(
    parameter bit         TERMINATE = 1'b1,
    parameter logic [7:0] SEP_DATE  = 8'h2D,
    parameter logic [7:0] SEP_TIME  = 8'h3A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] read_second,
    input  logic [7:0] read_minute,
    input  logic [7:0] read_hour,
    input  logic [7:0] read_date,
    input  logic [7:0] read_month,
    input  logic [7:0] read_week,
    input  logic [7:0] read_year,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       bcd_err,
    output logic [1:0] state_dbg
);

    localparam logic [4:0] LAST_IDX = TERMINATE ? 5'd22 : 5'd20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [4:0] idx, idx_n;
    logic [7:0] tx_data_n;
    logic       tx_valid_n;
    logic       cur_bad, cur_bad_n;
    logic       latch;

    // Snapshot of the masked time fields (control bits already stripped).
    logic [6:0] sec_q;
    logic [6:0] min_q;
    logic [5:0] hour_q;
    logic [5:0] date_q;
    logic [4:0] mon_q;
    logic [2:0] week_q;
    logic [7:0] year_q;

    // Byte for the position after the current one, with its "invalid digit" flag.
    logic [4:0] idx_nx;
    logic [8:0] nb;

    // One BCD nibble to ASCII; nibbles above 9 become '?' and are flagged.
    function automatic logic [8:0] bcd_char(input logic [3:0] n);
        logic [8:0] r;
        if (n > 4'd9) r = {1'b1, 8'h3F};
        else          r = {1'b0, 8'h30 + {4'h0, n}};
        return r;
    endfunction

    assign idx_nx    = idx + 5'd1;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    // Select the next record byte from the snapshot.
    always_comb begin
        nb = {1'b0, 8'h00};
        case (idx_nx)
            5'd1:  nb = {1'b0, 8'h30};
            5'd2:  nb = bcd_char(year_q[7:4]);
            5'd3:  nb = bcd_char(year_q[3:0]);
            5'd4:  nb = {1'b0, SEP_DATE};
            5'd5:  nb = bcd_char({3'b000, mon_q[4]});
            5'd6:  nb = bcd_char(mon_q[3:0]);
            5'd7:  nb = {1'b0, SEP_DATE};
            5'd8:  nb = bcd_char({2'b00, date_q[5:4]});
            5'd9:  nb = bcd_char(date_q[3:0]);
            5'd10: nb = {1'b0, 8'h20};
            5'd11: nb = bcd_char({2'b00, hour_q[5:4]});
            5'd12: nb = bcd_char(hour_q[3:0]);
            5'd13: nb = {1'b0, SEP_TIME};
            5'd14: nb = bcd_char({1'b0, min_q[6:4]});
            5'd15: nb = bcd_char(min_q[3:0]);
            5'd16: nb = {1'b0, SEP_TIME};
            5'd17: nb = bcd_char({1'b0, sec_q[6:4]});
            5'd18: nb = bcd_char(sec_q[3:0]);
            5'd19: nb = {1'b0, 8'h20};
            5'd20: nb = (week_q == 3'd0) ? {1'b1, 8'h3F} : {1'b0, 8'h30 + {5'b00000, week_q}};
            5'd21: nb = {1'b0, 8'h0D};
            5'd22: nb = {1'b0, 8'h0A};
            default: nb = {1'b0, 8'h00};
        endcase
    end

    // Next-state and next-output logic for the record FSM.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        cur_bad_n  = cur_bad;
        latch      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    latch      = 1'b1;
                    state_n    = S_SEND;
                    idx_n      = 5'd0;
                    tx_data_n  = 8'h32;
                    tx_valid_n = 1'b1;
                    cur_bad_n  = 1'b0;
                end
            end
            S_SEND: begin
                if (tx_valid && tx_ready) begin
                    if (idx == LAST_IDX) begin
                        state_n    = S_DONE;
                        idx_n      = 5'd0;
                        tx_data_n  = 8'h00;
                        tx_valid_n = 1'b0;
                        cur_bad_n  = 1'b0;
                    end else begin
                        idx_n      = idx_nx;
                        tx_data_n  = nb[7:0];
                        cur_bad_n  = nb[8];
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n    = S_IDLE;
                tx_valid_n = 1'b0;
            end
        endcase
    end

    // FSM state, index and registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            idx      <= 5'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            cur_bad  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            cur_bad  <= cur_bad_n;
        end
    end

    // Field snapshot taken only when a start is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            date_q <= '0;
            mon_q  <= '0;
            week_q <= '0;
            year_q <= '0;
        end else if (latch) begin
            sec_q  <= read_second[6:0];
            min_q  <= read_minute[6:0];
            hour_q <= read_hour[5:0];
            date_q <= read_date[5:0];
            mon_q  <= read_month[4:0];
            week_q <= read_week[2:0];
            year_q <= read_year;
        end
    end

    // Sticky error: set one edge after a '?' byte is loaded, cleared on start.
    always_ff @(posedge clk) begin
        if (!rst)         bcd_err <= 1'b0;
        else if (latch)   bcd_err <= 1'b0;
        else if (cur_bad) bcd_err <= 1'b1;
    end

endmodule

// File: tb/tb_rtc_time_ascii_tx.sv
// Directed bench for rtc_time_ascii_tx: record content, masking, invalid
// digits, stalls, ignored start, mid-record reset and the unterminated record.
module tb_rtc_time_ascii_tx;

  logic       clk;
  logic       rst;
  logic       start, start2;
  logic [7:0] read_second, read_minute, read_hour, read_date;
  logic [7:0] read_month, read_week, read_year;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_ready2;
  logic       busy, busy2, done, done2, bcd_err, bcd_err2;
  logic [1:0] state_dbg, state_dbg2;

  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rtc_time_ascii_tx dut (
    .clk(clk), .rst(rst), .start(start),
    .read_second(read_second), .read_minute(read_minute), .read_hour(read_hour),
    .read_date(read_date), .read_month(read_month), .read_week(read_week),
    .read_year(read_year),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .bcd_err(bcd_err), .state_dbg(state_dbg)
  );

  rtc_time_ascii_tx #(.TERMINATE(1'b0)) dut21 (
    .clk(clk), .rst(rst), .start(start2),
    .read_second(read_second), .read_minute(read_minute), .read_hour(read_hour),
    .read_date(read_date), .read_month(read_month), .read_week(read_week),
    .read_year(read_year),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .busy(busy2), .done(done2), .bcd_err(bcd_err2), .state_dbg(state_dbg2)
  );

  // driver tasks
  task automatic set_time(input logic [7:0] yy, mo, dd, hh, mi, ss, wk);
    read_year = yy; read_month = mo; read_date = dd; read_hour = hh;
    read_minute = mi; read_second = ss; read_week = wk;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Receive one record from dut (called at the negedge after start was sampled).
  // mode 0: tx_ready held high; mode 1: random ready with a 5-cycle stall at byte 8.
  task automatic collect(input string name, input string exp, input int mode,
                         input bit mid_change, input bit mid_start);
    int k, cyc, hold;
    bit stalled;
    logic pv, pr;
    logic [7:0] pd;
    k = 0; cyc = 0; hold = 0; stalled = 0; pv = 0; pr = 1; pd = 8'h00;
    while (k < exp.len() && cyc < 300) begin
      if (mode == 0) tx_ready = 1'b1;
      else if (hold > 0) begin tx_ready = 1'b0; hold--; end
      else if (k == 8 && !stalled) begin tx_ready = 1'b0; hold = 4; stalled = 1; end
      else tx_ready = ($urandom_range(0, 1) == 1);
      start = (mid_start && k == 3);
      if (mid_change && k == 5) set_time(8'h99, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
      if (pv && !pr) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== pd) begin
          n_bad++;
          $display("FAIL %s stall_hold byte %0d: got valid=%b data=%h want valid=1 data=%h",
                   name, k, tx_valid, tx_data, pd);
        end
      end
      if (mode == 0) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL %s gap byte %0d: got valid=%b busy=%b want 1 1", name, k, tx_valid, busy);
        end
      end
      if (tx_valid === 1'b1 && tx_ready) begin
        n_cmp++;
        if (tx_data !== exp[k]) begin
          n_bad++;
          $display("FAIL %s byte %0d: got %h want %h", name, k, tx_data, exp[k]);
        end
        k++;
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (k != exp.len()) begin
      n_bad++;
      $display("FAIL %s timeout: got %0d bytes want %0d", name, k, exp.len());
    end
    if (mode == 0) begin
      n_cmp++;
      if (cyc != exp.len()) begin
        n_bad++;
        $display("FAIL %s cycles: got %0d want %0d", name, cyc, exp.len());
      end
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1 || tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_cycle: got done=%b busy=%b valid=%b want 1 1 0", name, done, busy, tx_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  // test tasks
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || bcd_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got valid=%b data=%h busy=%b done=%b err=%b want 0 00 0 0 0",
               tx_valid, tx_data, busy, done, bcd_err);
    end
    n_cmp++;
    if (tx_valid2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset21: got valid=%b busy=%b done=%b want 0 0 0", tx_valid2, busy2, done2);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_time(8'h16, 8'h12, 8'h13, 8'h19, 8'h15, 8'h01, 8'h02);
    pulse_start();
    collect("basic", "2016-12-13 19:15:01 2\015\012", 0, 0, 0);
    n_cmp++;
    if (bcd_err !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_err: got %b want 0", bcd_err);
    end
  endtask

  task automatic test_mask();
    set_time(8'h16, 8'h12, 8'h13, 8'hD9, 8'h15, 8'h81, 8'h02);
    pulse_start();
    collect("mask", "2016-12-13 19:15:01 2\015\012", 0, 0, 0);
  endtask

  task automatic test_bad_digits();
    set_time(8'h16, 8'h12, 8'h13, 8'h19, 8'h5A, 8'h01, 8'h00);
    pulse_start();
    collect("bad", "2016-12-13 19:5?:01 ?\015\012", 0, 0, 0);
    n_cmp++;
    if (bcd_err !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_err_set: got %b want 1", bcd_err);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bcd_err !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_err_sticky: got %b want 1", bcd_err);
    end
  endtask

  task automatic test_stall_and_change();
    set_time(8'h16, 8'h12, 8'h13, 8'h19, 8'h15, 8'h01, 8'h02);
    pulse_start();
    n_cmp++;
    if (bcd_err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear_on_start: got %b want 0", bcd_err);
    end
    collect("stall", "2016-12-13 19:15:01 2\015\012", 1, 1, 0);
  endtask

  task automatic test_start_ignored();
    set_time(8'h16, 8'h12, 8'h13, 8'h19, 8'h15, 8'h01, 8'h02);
    pulse_start();
    collect("midstart", "2016-12-13 19:15:01 2\015\012", 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL midstart_extra cycle %0d: got valid=%b busy=%b want 0 0", i, tx_valid, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    string exp;
    exp = "2099-09-31 23:59:59 7\015\012";
    set_time(8'h99, 8'h09, 8'h31, 8'h23, 8'h59, 8'h59, 8'h07);
    pulse_start();
    repeat (8) @(negedge clk);
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== exp[8]) begin
      n_bad++;
      $display("FAIL rstmid_byte8: got valid=%b data=%h want 1 %h", tx_valid, tx_data, exp[8]);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_cmp++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL rstmid_abort: got valid=%b busy=%b done=%b data=%h want 0 0 0 00",
               tx_valid, busy, done, tx_data);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || tx_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_quiet cycle %0d: got done=%b valid=%b want 0 0", i, done, tx_valid);
      end
    end
    pulse_start();
    collect("restart", exp, 0, 0, 0);
  endtask

  task automatic test_no_term();
    string exp;
    int k;
    exp = "2099-09-31 23:59:59 7";
    set_time(8'h99, 8'h09, 8'h31, 8'h23, 8'h59, 8'h59, 8'h07);
    start2 = 1'b1;
    tx_ready2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (k = 0; k < exp.len(); k++) begin
      n_cmp++;
      if (tx_valid2 !== 1'b1 || tx_data2 !== exp[k]) begin
        n_bad++;
        $display("FAIL noterm byte %0d: got valid=%b data=%h want 1 %h", k, tx_valid2, tx_data2, exp[k]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (done2 !== 1'b1 || tx_valid2 !== 1'b0) begin
      n_bad++;
      $display("FAIL noterm_done: got done=%b valid=%b want 1 0", done2, tx_valid2);
    end
    @(negedge clk);
    n_cmp++;
    if (done2 !== 1'b0 || busy2 !== 1'b0) begin
      n_bad++;
      $display("FAIL noterm_idle: got done=%b busy=%b want 0 0", done2, busy2);
    end
  endtask

  // sequence and final report
  initial begin
    rst = 1'b0; start = 1'b0; start2 = 1'b0; tx_ready = 1'b0; tx_ready2 = 1'b0;
    set_time(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    test_reset();
    test_basic();
    test_mask();
    test_bad_digits();
    test_stall_and_change();
    test_start_ignored();
    test_reset_mid();
    test_no_term();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtc_time_ascii_tx.md
# rtc_time_ascii_tx

Downstream consumer of the DS1302 time-read controller's BCD registers (`read_second` … `read_year`). On a `start` pulse it snapshots the seven registers and serialises them as a fixed-length ASCII record, `20YY-MM-DD hh:mm:ss W` with an optional CR LF. Bytes leave on an 8-bit valid/ready stream that feeds the gating system's UART/log path. Malformed BCD digits are replaced by `?` and flagged.

## Interface
- `TERMINATE`, default 1: 1 appends CR (8'h0D) and LF (8'h0A), giving a 23-byte record; 0 gives a 21-byte record.
- `SEP_DATE`, default 8'h2D: date separator (`-`).
- `SEP_TIME`, default 8'h3A: time separator (`:`).
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  request one record; sampled only in IDLE.
- `read_second`, `read_minute`, `read_hour`, `read_date`, `read_month`, `read_week`, `read_year`  in  8 each  BCD time registers from the RTC read stage.
- `tx_data`  out  8  current ASCII byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte when high together with `tx_valid`.
- `busy`  out  1  record in progress (latched through emission).
- `done`  out  1  one-cycle pulse after the last byte is accepted.
- `bcd_err`  out  1  sticky flag: the last record contained an invalid digit; cleared on the next accepted `start`.

## Operation
- States:
  - IDLE: wait for `start`.
  - SEND: emit bytes in order.
  - DONE: pulse `done`, then return to IDLE.
- IDLE with `start`=1: latch the masked fields, clear `bcd_err`, set index 0, go to SEND.
- Field masks (control bits are dropped):
  - second[6:0] (CH removed), minute[6:0], hour[5:0] (24 h mode), date[5:0], month[4:0], week[2:0], year[7:0].
  - Masked fields are zero-extended to 8 bits before digit split.
- Digit conversion: each nibble 0–9 becomes 8'h30+nibble. A nibble above 9 becomes 8'h3F (`?`) and sets `bcd_err`. `week` is a single digit (low nibble); a value of 0 also yields `?` and sets `bcd_err`.
- Byte order, index 0..N-1:
  - `2`, `0`, Y1, Y0, SEP_DATE, M1, M0, SEP_DATE, D1, D0
  - space, h1, h0, SEP_TIME, m1, m0, SEP_TIME, s1, s0
  - space, W
  - then CR, LF when `TERMINATE`=1.
- Index is a 5-bit counter. It advances only on `tx_valid & tx_ready`.
  - Handshake on index N-1: go to DONE.
  - DONE lasts exactly one cycle: `done`=1, `busy`=1, `tx_valid`=0.
- `start` while not in IDLE is ignored. It is not queued.
- Input registers are not sampled after the latch. Changes mid-record do not affect the record.
- `tx_data` and `tx_valid` are held stable while `tx_valid`=1 and `tx_ready`=0. `tx_valid` never drops without a handshake, except on reset.

## Timing
- Reset (`rst`=0 at an edge):
  - State IDLE, index 0, `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `done`=0, `bcd_err`=0, latched fields 0.
  - Reset applied mid-record aborts at once. No partial completion and no `done`.
- Latency:
  - `start` sampled at edge t gives `tx_valid`=1 and `tx_data`=`2` from edge t (registered outputs, visible in the cycle after t).
  - `busy`=1 from edge t until DONE exits.
- Throughput with `tx_ready` held at 1: one byte per cycle. The last handshake is at edge t+N, `done` is high in the cycle after edge t+N, and the block is back in IDLE after edge t+N+1.
- Earliest next accepted `start`: edge t+N+2.
- `tx_data` is registered and updates on the same edge as the handshake that advances the index.
- `bcd_err` is updated on the edge after the offending byte is loaded into `tx_data` and holds until the next accepted `start`.

## Test plan
- Latch year 16, month 12, date 13, hour 19, minute 15, second 01, week 02 with `tx_ready`=1 and `start` pulsed. Required: stream `2016-12-13 19:15:01 2\r\n` (23 bytes, consecutive cycles), `done` one cycle later, `bcd_err`=0.
- Same input with second=8'h81 (CH set) and hour=8'hD9. Required: bits are masked, so the output shows `:01` and `19`.
- Minute=8'h5A, week=8'h00. Required: bytes `5?` for minutes and `?` for week, `bcd_err`=1 until the next `start`.
- `tx_ready` toggled randomly, held low 5 cycles mid-record. Required: `tx_data`/`tx_valid` stable while stalled, no byte lost or duplicated. Also change inputs mid-record: no effect on output.
- `start` pulsed during SEND. Required: ignored, exactly one record. `rst`=0 at byte 8. Required: next cycle `tx_valid`=0, `busy`=0, no `done`; a fresh `start` restarts at `2`.
- `TERMINATE`=0. Required: 21 bytes ending in `W`, `done` after byte 21.
